// File: rtl/aes_v1_mixcol.sv
// ---------------------------------------------------------------------------
// aes_v1_mixcol
//
// Purpose:
//   MixColumns / InvMixColumns stage that sits after the v1 AES SubBytes unit.
//   One 32-bit state column comes in on a valid/ready handshake. The result is
//   registered and held on a valid/ready handshake until it is consumed.
//
//   With INV_TWO_STEP = 1, InvMixColumns is done as a preprocessing pass
//   followed by the forward MixColumns. Both passes use the same MixColumns
//   datapath, so decryption takes two cycles. With INV_TWO_STEP = 0, the
//   preprocessing and MixColumns are chained combinationally, so decryption
//   takes one cycle.
//
// Ports:
//   g_clk      in   1   clock, all state updates on the rising edge
//   g_reset    in   1   synchronous reset, active-high
//   in_valid   in   1   rs1/dec are valid this cycle
//   in_ready   out  1   stage can accept (transfer when in_valid & in_ready)
//   dec        in   1   0 = MixColumns, 1 = InvMixColumns (sampled on accept)
//   rs1        in   32  column {a3,a2,a1,a0}, a0 = rs1[7:0]
//   out_valid  out  1   rd holds a result
//   out_ready  in   1   consumer takes rd when out_valid & out_ready
//   rd         out  32  result {b3,b2,b1,b0}; zero when out_valid = 0
//   busy       out  1   stage is not idle
// ---------------------------------------------------------------------------
module aes_v1_mixcol #(
  parameter bit INV_TWO_STEP = 1'b1
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        dec,
  input  logic [31:0] rs1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] rd,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] result_q, result_d;

  logic        accept;
  logic [31:0] pre_out;
  logic [31:0] mix_in;
  logic [31:0] mix_out;

  // Multiply by x in GF(2^8), reduction polynomial 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  // Forward MixColumns on one column. The 3*a term is formed as 2*a ^ a,
  // so each byte needs only one xtime.
  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] x2 [4];
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[8*i +: 8];
      x2[i] = xtime(c[8*i +: 8]);
    end
    for (int i = 0; i < 4; i++) begin
      b[i] = x2[i] ^ x2[(i+1)%4] ^ a[(i+1)%4] ^ a[(i+2)%4] ^ a[(i+3)%4];
    end
    mix_col = {b[3], b[2], b[1], b[0]};
  endfunction

  // Preprocessing that turns the forward MixColumns into InvMixColumns:
  // the even bytes both get 4*(a0^a2), and the odd bytes both get 4*(a1^a3).
  function automatic logic [31:0] pre_col(input logic [31:0] c);
    logic [7:0] u;
    logic [7:0] v;
    u = xtime(xtime(c[7:0]  ^ c[23:16]));
    v = xtime(xtime(c[15:8] ^ c[31:24]));
    pre_col = {c[31:24] ^ v, c[23:16] ^ u, c[15:8] ^ v, c[7:0] ^ u};
  endfunction

  assign pre_out = pre_col(rs1);

  // The single MixColumns instance. In PRE it finishes the held preprocessed
  // column. Otherwise it works on the incoming column, which is preprocessed
  // first for a dec accept. In two-step mode the dec-accept value is never
  // stored, because that path loads pre_out instead.
  always_comb begin
    mix_in = rs1;
    if (state_q == PRE) begin
      mix_in = result_q;
    end else if (dec) begin
      mix_in = pre_out;
    end
  end

  assign mix_out = mix_col(mix_in);

  // Handshake outputs. in_ready is the only output that depends on a live
  // input (out_ready), and only in OUT, so a result can be handed over and
  // the next column taken in the same cycle.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    rd        = 32'h0;
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
      end
      OUT: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
        rd        = result_q;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign accept = in_valid & in_ready;

  // Next state and result register. An accept from OUT is treated exactly
  // like an accept from IDLE, which gives back-to-back throughput.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    case (state_q)
      IDLE, OUT: begin
        if (accept) begin
          if (dec && INV_TWO_STEP) begin
            result_d = pre_out;
            state_d  = PRE;
          end else begin
            result_d = mix_out;
            state_d  = OUT;
          end
        end else if (state_q == OUT && out_ready) begin
          state_d = IDLE;
        end
      end
      PRE: begin
        result_d = mix_out;
        state_d  = OUT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register. Reset drops any pending column.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q  <= IDLE;
      result_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_aes_v1_mixcol.sv
// ---------------------------------------------------------------------------
// tb_aes_v1_mixcol
//
// Purpose:
//   Self-checking bench for aes_v1_mixcol in two-step InvMixColumns mode.
//   A behavioural model built from GF(2^8) matrix products predicts
//   out_valid, rd, in_ready and busy. These are compared on every falling
//   edge. Directed sequences pin known AES column vectors. Randomized traffic
//   with random backpressure and occasional resets follows.
// ---------------------------------------------------------------------------
module tb_aes_v1_mixcol;

  localparam bit TWO_STEP = 1'b1;

  logic        g_clk = 1'b0;
  logic        g_reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        dec = 1'b0;
  logic [31:0] rs1 = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] rd;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  aes_v1_mixcol #(.INV_TWO_STEP(TWO_STEP)) dut (
    .g_clk     (g_clk),
    .g_reset   (g_reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dec       (dec),
    .rs1       (rs1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rd        (rd),
    .busy      (busy)
  );

  always #5 g_clk = ~g_clk;

  // Reference GF(2^8) arithmetic: shift-and-add multiply, modulo 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
    end
    return p;
  endfunction

  // Circulant matrix product with first row {c0,c1,c2,c3}.
  function automatic logic [31:0] circ(input logic [31:0] col, input logic [7:0] c0,
                                       input logic [7:0] c1, input logic [7:0] c2,
                                       input logic [7:0] c3);
    logic [7:0] a [4];
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++) a[i] = col[8*i +: 8];
    for (int i = 0; i < 4; i++)
      b[i] = gmul(c0, a[i]) ^ gmul(c1, a[(i+1)%4]) ^ gmul(c2, a[(i+2)%4]) ^ gmul(c3, a[(i+3)%4]);
    return {b[3], b[2], b[1], b[0]};
  endfunction

  function automatic logic [31:0] model_result(input logic d, input logic [31:0] col);
    return d ? circ(col, 8'h0E, 8'h0B, 8'h0D, 8'h09) : circ(col, 8'h02, 8'h03, 8'h01, 8'h01);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Behavioural model: at most one column is in flight. It is either still
  // waiting out its extra dec cycle or being presented as the result.
  logic        m_started = 1'b0;
  logic        m_wait    = 1'b0;
  logic        m_have    = 1'b0;
  logic [31:0] m_data    = 32'h0;
  logic        m_in_ready;

  always_comb m_in_ready = !m_wait && (!m_have || out_ready);

  always @(posedge g_clk) begin
    if (g_reset) begin
      m_started = 1'b1;
      m_wait    = 1'b0;
      m_have    = 1'b0;
      m_data    = 32'h0;
    end else if (m_wait) begin
      m_wait = 1'b0;
      m_have = 1'b1;
    end else if (in_valid && m_in_ready) begin
      m_data = model_result(dec, rs1);
      m_wait = dec && TWO_STEP;
      m_have = !(dec && TWO_STEP);
    end else if (m_have && out_ready) begin
      m_have = 1'b0;
    end
  end

  always @(negedge g_clk) begin
    if (m_started) begin
      checkOutput("out_valid", {31'h0, out_valid}, {31'h0, m_have});
      checkOutput("rd", rd, m_have ? m_data : 32'h0);
      checkOutput("in_ready", {31'h0, in_ready}, {31'h0, m_in_ready});
      checkOutput("busy", {31'h0, busy}, {31'h0, m_wait || m_have});
    end
  end

  task automatic step();
    @(posedge g_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic d, input logic [31:0] data,
                               input logic ordy);
    in_valid  = v;
    dec       = d;
    rs1       = data;
    out_ready = ordy;
  endtask

  // Send one column with the output free. Then measure how many falling
  // edges pass before out_valid appears, and check the value.
  task automatic sendAndCheck(input string name, input logic d, input logic [31:0] data,
                              input logic [31:0] exp, input int exp_lat);
    int lat;
    applyStimulus(1'b1, d, data, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    lat = -1;
    for (int k = 0; k < 6; k++) begin
      @(negedge g_clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    checkOutput({name, "_latency"}, lat, exp_lat);
    checkOutput(name, rd, exp);
    step();
  endtask

  initial begin
    logic [31:0] vec [4];
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    g_reset = 1'b1;
    step();
    step();
    g_reset = 1'b0;
    @(negedge g_clk);
    checkOutput("reset_out_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("reset_rd", rd, 32'h0);
    checkOutput("reset_in_ready", {31'h0, in_ready}, 32'h1);
    step();

    $display("[TB] directed vectors");
    sendAndCheck("enc_455313db", 1'b0, 32'h455313db, 32'hbca14d8e, 0);
    sendAndCheck("dec_bca14d8e", 1'b1, 32'hbca14d8e, 32'h455313db, 1);
    sendAndCheck("enc_5c220af2", 1'b0, 32'h5c220af2, 32'h9d58dc9f, 0);
    sendAndCheck("enc_c6c6c6c6", 1'b0, 32'hc6c6c6c6, 32'hc6c6c6c6, 0);
    sendAndCheck("dec_01010101", 1'b1, 32'h01010101, 32'h01010101, 1);

    $display("[TB] backpressure hold");
    applyStimulus(1'b1, 1'b0, 32'h455313db, 1'b0);
    step();
    applyStimulus(1'b1, 1'b0, 32'h5c220af2, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge g_clk);
      checkOutput("hold_rd", rd, 32'hbca14d8e);
      checkOutput("hold_in_ready", {31'h0, in_ready}, 32'h0);
      step();
    end
    applyStimulus(1'b1, 1'b0, 32'h5c220af2, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge g_clk);
    checkOutput("after_hold_rd", rd, 32'h9d58dc9f);
    step();

    $display("[TB] back-to-back enc");
    for (int k = 0; k < 4; k++) vec[k] = $urandom;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, vec[k], 1'b1);
      step();
      @(negedge g_clk);
      checkOutput("b2b_rd", rd, model_result(1'b0, vec[k]));
      #1;
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    step();

    $display("[TB] reset during PRE");
    applyStimulus(1'b1, 1'b1, 32'hbca14d8e, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    g_reset = 1'b1;
    step();
    g_reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge g_clk);
      checkOutput("drop_out_valid", {31'h0, out_valid}, 32'h0);
      checkOutput("drop_rd", rd, 32'h0);
      step();
    end

    $display("[TB] random traffic");
    for (int k = 0; k < 600; k++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom,
                    $urandom_range(0, 2) != 0);
      g_reset = ($urandom_range(0, 59) == 0);
      step();
    end
    g_reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    step();
    step();

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
